// File: rtl/data_stream_writer_if.sv
// Interface I: one 8-bit data_t word, writer view P1, reader view P2.
// P1 drives data; P2 samples it every cycle.
interface I;
  typedef logic [7:0] data_t;
  data_t data;
  modport P1 (output data);
  modport P2 (input data);
endinterface

// File: rtl/data_stream_writer.sv
// data_stream_writer: buffers pushed bytes in a FIFO and shows each on
// p1.data for HOLD_CYCLES clocks, IDLE_VAL when nothing is being sent.
// Ports: i_clk, i_rst (sync, active-high), i_valid/i_data/o_ready push
// port, p1 (I.P1 writer view), o_busy (SEND), o_sent (last hold cycle),
// o_count (FIFO occupancy).
module data_stream_writer #(
  parameter int         DEPTH       = 4,
  parameter int         HOLD_CYCLES = 2,
  parameter logic [7:0] IDLE_VAL    = 8'h00
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [7:0]                 i_data,
  output logic                       o_ready,
  I.P1                               p1,
  output logic                       o_busy,
  output logic                       o_sent,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  state_t          state_n;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [HW-1:0]   hold;
  logic [HW-1:0]   hold_n;
  logic [7:0]      data_q;
  logic [7:0]      data_n;
  logic            push;
  logic            pop;
  logic            sent;
  logic            has_word;

  // Ready depends only on occupancy, not on a same-cycle pop.
  assign o_ready  = count < CW'(DEPTH);
  assign push     = i_valid && o_ready;
  assign has_word = count != '0;

  always_comb begin
    state_n = state;
    hold_n  = hold;
    data_n  = data_q;
    pop     = 1'b0;
    sent    = 1'b0;
    unique case (state)
      IDLE: begin
        data_n = IDLE_VAL;
        if (has_word) begin
          pop     = 1'b1;
          data_n  = mem[rd_ptr];
          hold_n  = HW'(1);
          state_n = SEND;
        end
      end
      SEND: begin
        if (hold < HW'(HOLD_CYCLES)) begin
          hold_n = hold + HW'(1);
        end else begin
          sent = 1'b1;
          if (has_word) begin
            // Chain straight into the next word: no idle gap.
            pop    = 1'b1;
            data_n = mem[rd_ptr];
            hold_n = HW'(1);
          end else begin
            data_n  = IDLE_VAL;
            hold_n  = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        data_n  = IDLE_VAL;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      hold   <= '0;
      data_q <= IDLE_VAL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_n;
      hold   <= hold_n;
      data_q <= data_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  assign p1.data = data_q;
  assign o_busy  = state == SEND;
  assign o_sent  = sent;
  assign o_count = count;

endmodule

// File: tb/tb_data_stream_writer.sv
// Directed bench for data_stream_writer: HOLD_CYCLES=2 instance (a)
// and HOLD_CYCLES=1 instance (b) on a shared clock and reset.
module tb_data_stream_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_a, valid_b;
  logic [7:0] din_a, din_b;
  logic       ready_a, ready_b;
  logic       busy_a, busy_b;
  logic       sent_a, sent_b;
  logic [2:0] count_a, count_b;

  int vectors = 0;
  int errors  = 0;

  I bus_a ();
  I bus_b ();

  data_stream_writer #(.DEPTH(4), .HOLD_CYCLES(2), .IDLE_VAL(8'h00)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .i_data(din_a),
    .o_ready(ready_a), .p1(bus_a.P1), .o_busy(busy_a),
    .o_sent(sent_a), .o_count(count_a)
  );

  data_stream_writer #(.DEPTH(4), .HOLD_CYCLES(1), .IDLE_VAL(8'h00)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .i_data(din_b),
    .o_ready(ready_b), .p1(bus_b.P1), .o_busy(busy_b),
    .o_sent(sent_b), .o_count(count_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp3_d [8];
  logic       exp3_s [8];
  logic [7:0] exp4_d [18];
  logic [2:0] exp4_c [18];
  logic [7:0] exp6_d [5];
  logic       exp6_s [5];
  int         pulses;

  initial begin
    exp3_d = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h00};
    exp3_s = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp4_d = '{8'h00, 8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h13,
               8'h13, 8'h14, 8'h14, 8'h15, 8'h15, 8'h16, 8'h16, 8'h18,
               8'h18, 8'h00};
    exp4_c = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd3,
               3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0,
               3'd0, 3'd0};
    exp6_d = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    exp6_s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held with pushes requested.
    rst     = 1'b1;
    valid_a = 1'b1;
    din_a   = 8'h77;
    valid_b = 1'b1;
    din_b   = 8'h77;
    repeat (3) tick();
    chk("rst_data", bus_a.data, 8'h00);
    chk("rst_count", count_a, 3'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_ready", ready_a, 1'b1);
    chk("rst_sent", sent_a, 1'b0);
    rst     = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    tick();
    chk("post_rst_count", count_a, 3'd0);
    chk("post_rst_data", bus_a.data, 8'h00);

    // Single word.
    valid_a = 1'b1;
    din_a   = 8'hA5;
    tick();
    valid_a = 1'b0;
    chk("w1_count", count_a, 3'd1);
    chk("w1_data_n", bus_a.data, 8'h00);
    tick();
    chk("w1_data_n1", bus_a.data, 8'hA5);
    chk("w1_busy_n1", busy_a, 1'b1);
    chk("w1_sent_n1", sent_a, 1'b0);
    tick();
    chk("w1_data_n2", bus_a.data, 8'hA5);
    chk("w1_sent_n2", sent_a, 1'b1);
    tick();
    chk("w1_data_n3", bus_a.data, 8'h00);
    chk("w1_busy_n3", busy_a, 1'b0);
    chk("w1_sent_n3", sent_a, 1'b0);

    // Back-to-back three words.
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      valid_a = k < 3;
      din_a   = 8'(k + 1);
      tick();
      chk($sformatf("b2b_data%0d", k), bus_a.data, exp3_d[k]);
      chk($sformatf("b2b_sent%0d", k), sent_a, exp3_s[k]);
      if (sent_a) pulses++;
    end
    valid_a = 1'b0;
    chk("b2b_pulses", pulses, 3);
    chk("b2b_busy_end", busy_a, 1'b0);

    // Overfill: 0x10..0x19 one per cycle; 0x17 and 0x19 hit a full FIFO.
    for (int k = 0; k < 18; k++) begin
      valid_a = k < 10;
      din_a   = 8'(8'h10 + k);
      tick();
      chk($sformatf("full_data%0d", k), bus_a.data, exp4_d[k]);
      chk($sformatf("full_count%0d", k), count_a, exp4_c[k]);
      chk($sformatf("full_ready%0d", k), ready_a, exp4_c[k] != 3'd4);
    end
    valid_a = 1'b0;
    chk("full_busy_end", busy_a, 1'b0);

    // Reset while 0xC3 is shown and two words are queued.
    valid_a = 1'b1;
    din_a   = 8'hC3;
    tick();
    din_a   = 8'hD1;
    tick();
    din_a   = 8'hD2;
    tick();
    chk("mid_data", bus_a.data, 8'hC3);
    chk("mid_count", count_a, 3'd2);
    valid_a = 1'b0;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    chk("mid_rst_data", bus_a.data, 8'h00);
    chk("mid_rst_count", count_a, 3'd0);
    chk("mid_rst_busy", busy_a, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mid_quiet%0d", k), bus_a.data, 8'h00);
    end

    // HOLD_CYCLES=1 streaming.
    for (int k = 0; k < 5; k++) begin
      valid_b = k < 3;
      din_b   = (k == 0) ? 8'hAA : (k == 1) ? 8'hBB : 8'hCC;
      tick();
      chk($sformatf("h1_data%0d", k), bus_b.data, exp6_d[k]);
      chk($sformatf("h1_sent%0d", k), sent_b, exp6_s[k]);
    end
    valid_b = 1'b0;
    chk("h1_busy_end", busy_b, 1'b0);
    chk("h1_count_end", count_b, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
